// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
//
// Contents:
//   DEFAULT_WIDTH        default operand/result width
//   DEFAULT_BLOCK_WIDTH  default number of bits resolved per pipeline stage
//   split_is_valid()     true when the operand width divides into whole blocks
package pipelined_carry_select_adder_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_BLOCK_WIDTH = 8;

    function automatic bit split_is_valid(input int width, input int block_width);
        return (block_width > 0) && (width >= block_width) && ((width % block_width) == 0);
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_stage.sv
// carry_select_stage: combinational carry-select block for one pipeline stage.
// Both carry-in hypotheses are evaluated in parallel and the real carry-in
// picks one of them.
//
// Ports:
//   a, b          in   BLOCK_WIDTH  operand slices (b already inverted for subtract)
//   carry_in      in   1            carry from the previous block
//   sum           out  BLOCK_WIDTH  selected sum slice
//   carry_out     out  1            carry out of the block MSB
//   msb_carry_in  out  1            carry into the block MSB (for signed overflow)
module carry_select_stage
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
    input  logic [BLOCK_WIDTH-1:0] a,
    input  logic [BLOCK_WIDTH-1:0] b,
    input  logic                   carry_in,
    output logic [BLOCK_WIDTH-1:0] sum,
    output logic                   carry_out,
    output logic                   msb_carry_in
);

    logic [BLOCK_WIDTH:0] res_c0;
    logic [BLOCK_WIDTH:0] res_c1;

    assign res_c0 = {1'b0, a} + {1'b0, b};
    assign res_c1 = {1'b0, a} + {1'b0, b} + (BLOCK_WIDTH + 1)'(1);

    assign sum       = carry_in ? res_c1[BLOCK_WIDTH-1:0] : res_c0[BLOCK_WIDTH-1:0];
    assign carry_out = carry_in ? res_c1[BLOCK_WIDTH]     : res_c0[BLOCK_WIDTH];

    // The carry into the MSB is the carry out of the lower BLOCK_WIDTH-1 bits,
    // also precomputed for both carry-in values. A 1-bit block has no lower
    // bits, so its MSB carry-in is simply the block carry-in.
    if (BLOCK_WIDTH == 1) begin : g_msb_single
        assign msb_carry_in = carry_in;
    end else begin : g_msb_multi
        logic [BLOCK_WIDTH-1:0] low_c0;
        logic [BLOCK_WIDTH-1:0] low_c1;

        assign low_c0       = {1'b0, a[BLOCK_WIDTH-2:0]} + {1'b0, b[BLOCK_WIDTH-2:0]};
        assign low_c1       = low_c0 + BLOCK_WIDTH'(1);
        assign msb_carry_in = carry_in ? low_c1[BLOCK_WIDTH-1] : low_c0[BLOCK_WIDTH-1];
    end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: registered carry-select adder/subtractor with a
// valid/ready stream interface. Stage k resolves bits [k*BLOCK_WIDTH +: BLOCK_WIDTH]
// and carries the still-unresolved upper operand bits forward, so a result
// appears WIDTH/BLOCK_WIDTH cycles after acceptance. A single global stall
// (advance) freezes every stage when the output is blocked.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid is also high
//   a, b       in   WIDTH  operands
//   carry_in   in   1      carry into bit 0 (ignored when subtracting)
//   sub        in   1      1 = a - b
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   carry_out  out  1      carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  1      two's-complement signed overflow
module pipelined_carry_select_adder
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK_WIDTH;

    if (!split_is_valid(WIDTH, BLOCK_WIDTH)) begin : g_bad_split
        $error("pipelined_carry_select_adder: WIDTH must be a multiple of BLOCK_WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             carry_entry;

    // in_ready depends only on the output handshake, never on in_valid.
    assign advance     = !out_valid || out_ready;
    assign in_ready    = advance;

    // Subtraction is a + ~b + 1, so the entry carry is forced to 1.
    assign b_eff       = sub ? ~b : b;
    assign carry_entry = sub ? 1'b1 : carry_in;

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
        localparam int LO_W = (k + 1) * BLOCK_WIDTH;

        logic [BLOCK_WIDTH-1:0] blk_a;
        logic [BLOCK_WIDTH-1:0] blk_b;
        logic                   blk_cin;
        logic [BLOCK_WIDTH-1:0] blk_sum;
        logic                   blk_cout;
        logic                   blk_msb_carry;
        logic                   valid_d;
        logic [LO_W-1:0]        sum_d;

        logic                   valid_q;
        logic                   carry_q;
        logic [LO_W-1:0]        sum_q;

        // Stage 0 takes its block straight from the ports; later stages take
        // the lowest unresolved slice and the carry registered by the stage before.
        if (k == 0) begin : g_src
            assign blk_a   = a[BLOCK_WIDTH-1:0];
            assign blk_b   = b_eff[BLOCK_WIDTH-1:0];
            assign blk_cin = carry_entry;
            assign valid_d = in_valid;
            assign sum_d   = blk_sum;
        end else begin : g_src
            assign blk_a   = g_stage[k-1].g_ops.a_hi[BLOCK_WIDTH-1:0];
            assign blk_b   = g_stage[k-1].g_ops.b_hi[BLOCK_WIDTH-1:0];
            assign blk_cin = g_stage[k-1].carry_q;
            assign valid_d = g_stage[k-1].valid_q;
            assign sum_d   = {blk_sum, g_stage[k-1].sum_q};
        end

        carry_select_stage #(
            .BLOCK_WIDTH (BLOCK_WIDTH)
        ) u_carry_select_stage (
            .a            (blk_a),
            .b            (blk_b),
            .carry_in     (blk_cin),
            .sum          (blk_sum),
            .carry_out    (blk_cout),
            .msb_carry_in (blk_msb_carry)
        );

        // A bubble (valid_d = 0) still shifts through; its data is don't-care.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= blk_cout;
                sum_q   <= sum_d;
            end
        end

        // Upper operand bits that later stages still have to resolve.
        if (k < NUM_BLOCKS - 1) begin : g_ops
            localparam int HI_W = WIDTH - LO_W;

            logic [HI_W-1:0] a_hi_d;
            logic [HI_W-1:0] b_hi_d;
            logic [HI_W-1:0] a_hi;
            logic [HI_W-1:0] b_hi;

            if (k == 0) begin : g_in
                assign a_hi_d = a[WIDTH-1:BLOCK_WIDTH];
                assign b_hi_d = b_eff[WIDTH-1:BLOCK_WIDTH];
            end else begin : g_in
                assign a_hi_d = g_stage[k-1].g_ops.a_hi[HI_W+BLOCK_WIDTH-1:BLOCK_WIDTH];
                assign b_hi_d = g_stage[k-1].g_ops.b_hi[HI_W+BLOCK_WIDTH-1:BLOCK_WIDTH];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (advance) begin
                    a_hi <= a_hi_d;
                    b_hi <= b_hi_d;
                end
            end
        end

        // Signed overflow only has meaning at the true MSB of the word.
        if (k == NUM_BLOCKS - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= blk_cout ^ blk_msb_carry;
                end
            end
        end else begin : g_mid
            logic unused_msb_carry;
            assign unused_msb_carry = blk_msb_carry;
        end
    end

    assign out_valid = g_stage[NUM_BLOCKS-1].valid_q;
    assign sum       = g_stage[NUM_BLOCKS-1].sum_q;
    assign carry_out = g_stage[NUM_BLOCKS-1].carry_q;
    assign overflow  = g_stage[NUM_BLOCKS-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder (WIDTH=16, BLOCK_WIDTH=4).
// Directed vectors come from a table with hand-derived results; random beats
// are checked against an arithmetic reference model through an in-order queue.
module tb_pipelined_carry_select_adder;

    localparam int WIDTH       = 16;
    localparam int BLOCK_WIDTH = 4;
    localparam int LATENCY     = WIDTH / BLOCK_WIDTH;
    localparam int NUM_VECTORS = 11;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          cycle        = 0;
    bit          check_latency = 1'b0;
    bit          last_accepted = 1'b0;
    bit          prev_stalled  = 1'b0;
    logic [15:0] prev_sum;
    logic        prev_cout;
    logic        prev_ovf;
    exp_t        pending;
    exp_t        sb[$];

    pipelined_carry_select_adder #(
        .WIDTH       (WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic vec_t ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                       input logic rcin, input logic rsub);
        vec_t v;
        int   ua;
        int   ub;
        int   sa;
        int   sbv;
        int   total;
        int   sres;
        ua  = int'(ra);
        ub  = int'(rb);
        sa  = int'($signed(ra));
        sbv = int'($signed(rb));
        if (rsub) begin
            total  = ua - ub;
            sres   = sa - sbv;
            v.cout = (ua >= ub);
        end else begin
            total  = ua + ub + int'(rcin);
            sres   = sa + sbv + int'(rcin);
            v.cout = (total > 65535);
        end
        v.a   = ra;
        v.b   = rb;
        v.cin = rcin;
        v.sub = rsub;
        v.sum = total[15:0];
        v.ovf = (sres > 32767) || (sres < -32768);
        return v;
    endfunction

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        n_compared++;
        if (actual !== required) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)",
                     name, actual, required, cycle);
        end
    endtask

    task automatic applyStimulus(input logic valid, input vec_t v);
        in_valid     = valid;
        a            = v.a;
        b            = v.b;
        carry_in     = v.cin;
        sub          = v.sub;
        pending.sum  = v.sum;
        pending.cout = v.cout;
        pending.ovf  = v.ovf;
        pending.t    = 0;
    endtask

    // One clock: observe both handshakes away from the edge, then advance.
    task automatic step();
        exp_t e;
        #1;
        last_accepted = 1'b0;
        if (rst_n === 1'b1) begin
            if (prev_stalled) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_sum", 32'(sum), 32'(prev_sum));
                checkOutput("hold_carry", 32'(carry_out), 32'(prev_cout));
                checkOutput("hold_ovf", 32'(overflow), 32'(prev_ovf));
            end
            if (in_valid && in_ready) begin
                e   = pending;
                e.t = cycle;
                sb.push_back(e);
                last_accepted = 1'b1;
            end
            if (out_valid && !out_ready) begin
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_beat: actual sum 0x%0h required no beat (cycle %0d)",
                             sum, cycle);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sum", 32'(sum), 32'(e.sum));
                    checkOutput("carry_out", 32'(carry_out), 32'(e.cout));
                    checkOutput("overflow", 32'(overflow), 32'(e.ovf));
                    if (check_latency) begin
                        checkOutput("latency", 32'(cycle - e.t), 32'(LATENCY));
                    end
                end
            end
            prev_stalled = out_valid && !out_ready;
            prev_sum     = sum;
            prev_cout    = carry_out;
            prev_ovf     = overflow;
        end else begin
            prev_stalled = 1'b0;
        end
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            step();
        end
        checkOutput(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t vectors[NUM_VECTORS];
        vec_t v;
        bit   have_beat;

        vectors[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vectors[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vectors[2]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vectors[3]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vectors[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vectors[5]  = '{16'h00FF, 16'hFF01, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vectors[6]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b1};
        vectors[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vectors[8]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vectors[9]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vectors[10] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset held for three edges while a beat is offered.
        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b1, vectors[0]);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_carry_out", 32'(carry_out), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed table, back-to-back with no stall.
        $display("[TB] directed vectors");
        check_latency = 1'b1;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            applyStimulus(1'b1, vectors[i]);
            step();
        end
        drain("table_drain");

        // Random stream with backpressure, including a 5-cycle stall with input held.
        $display("[TB] random stream with backpressure");
        check_latency = 1'b0;
        have_beat     = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!have_beat) begin
                if ((i >= 20 && i < 30) || $urandom_range(0, 4) != 0) begin
                    v = ref_model(rand_operand(), rand_operand(), 1'($urandom), 1'($urandom));
                    applyStimulus(1'b1, v);
                    have_beat = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (i >= 25 && i < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
            if (last_accepted) begin
                have_beat = 1'b0;
            end
        end
        drain("random_drain");

        // Reset with three beats in flight: none may emerge, next beat has full latency.
        $display("[TB] reset mid-flight");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = ref_model(rand_operand(), rand_operand(), 1'($urandom), 1'($urandom));
            applyStimulus(1'b1, v);
            step();
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        step();
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        rst_n         = 1'b1;
        check_latency = 1'b1;
        v = ref_model(16'h4321, 16'h1234, 1'b1, 1'b0);
        applyStimulus(1'b1, v);
        step();
        drain("post_reset_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
